// File: rtl/weight_fetch_ctrl.sv
// rtl/weight_fetch_ctrl.sv - weight ROM read sequencer with 2-entry output buffer toward the systolic array
//
// Purpose: on start, reads num_words consecutive ROM words beginning at
// base_addr (wrapping at 2^ADDR_DW), then streams them to the array over a
// valid/ready handshake. A 2-entry buffer absorbs array backpressure.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle request, honoured only in IDLE
//   base_addr    first ROM address, sampled with start
//   num_words    burst length 0..ROM_SIZE (larger values clamp), sampled with start
//   busy         high from the cycle after an accepted start through DONE
//   done         one-cycle pulse after the last word is accepted
//   rom_en       ROM read enable
//   rom_addr     ROM read address
//   rom_dout     ROM registered read data, valid the cycle after rom_en
//   w_data       head-of-buffer weight
//   w_valid      buffer non-empty
//   w_ready      array ready
//   w_last       head word is the final word of the burst
module weight_fetch_ctrl #(
    parameter int DW       = 8,
    parameter int ADDR_DW  = 5,
    parameter int ROM_SIZE = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_DW-1:0] base_addr,
    input  logic [ADDR_DW:0]   num_words,
    output logic               busy,
    output logic               done,
    output logic               rom_en,
    output logic [ADDR_DW-1:0] rom_addr,
    input  logic [DW:0]        rom_dout,
    output logic [DW:0]        w_data,
    output logic               w_valid,
    input  logic               w_ready,
    output logic               w_last
);

    localparam int CW = ADDR_DW + 1;
    localparam logic [CW-1:0] MAX_WORDS = CW'(ROM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_DW-1:0] base_q, base_d;
    logic [CW-1:0]      num_q, num_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               inflight_q, inflight_d;
    logic               infl_last_q, infl_last_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [1:0]         occ_q, occ_d;
    // Each entry carries {last tag, data}.
    logic [DW+1:0]      mem_q [2];

    logic [CW-1:0]      num_clamped;
    logic [DW+1:0]      head;
    logic               push;
    logic               pop;
    logic [1:0]         level;
    logic               issue_ok;
    logic               last_issue;

    always_comb begin
        num_clamped = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
        head        = mem_q[rd_ptr_q];
        push        = inflight_q;
        pop         = (occ_q != 2'd0) && w_ready;
        // Words already committed to the buffer after this cycle's pop; a new
        // read is only issued if its data is guaranteed a free slot.
        level       = occ_q + {1'b0, inflight_q};
        issue_ok    = (level - {1'b0, pop}) < 2'd2;
        last_issue  = (cnt_q == num_q - 1'b1);

        rom_en   = (state_q == S_FETCH) && issue_ok;
        rom_addr = base_q + cnt_q[ADDR_DW-1:0];
        w_valid  = (occ_q != 2'd0);
        w_data   = head[DW:0];
        w_last   = w_valid && head[DW+1];
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        num_d       = num_q;
        cnt_d       = cnt_q;
        inflight_d  = rom_en;
        infl_last_d = rom_en && last_issue;
        rd_ptr_d    = pop  ? ~rd_ptr_q : rd_ptr_q;
        wr_ptr_d    = push ? ~wr_ptr_q : wr_ptr_q;
        occ_d       = occ_q + {1'b0, push} - {1'b0, pop};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    num_d   = num_clamped;
                    cnt_d   = '0;
                    state_d = (num_clamped == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (rom_en) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_issue) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The tagged last word leaving the buffer implies nothing is
                // left in flight or buffered behind it.
                if (pop && head[DW+1]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            num_q       <= '0;
            cnt_q       <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            num_q       <= num_d;
            cnt_q       <= cnt_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {infl_last_q, rom_dout};
            end
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (occ_q == 2'd2)));

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// tb/tb_weight_fetch_ctrl.sv - randomized self-checking bench for weight_fetch_ctrl
module tb_weight_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] base_addr = '0;
    logic [5:0] num_words = '0;
    logic       busy, done, rom_en, w_valid, w_last;
    logic [4:0] rom_addr;
    logic [8:0] rom_dout = '0;
    logic [8:0] w_data;
    logic       w_ready = 1'b0;

    logic [8:0] rom_mem [32];

    int total = 0;
    int bad   = 0;

    weight_fetch_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .w_data    (w_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_last    (w_last)
    );

    always #5 clk = ~clk;

    // Registered ROM: drives 0 whenever it was not enabled.
    always @(posedge clk) begin
        rom_dout <= rom_en ? rom_mem[rom_addr] : 9'd0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy",    32'(busy),     0);
        chk("rst_done",    32'(done),     0);
        chk("rst_rom_en",  32'(rom_en),   0);
        chk("rst_rom_addr",32'(rom_addr), 0);
        chk("rst_w_valid", 32'(w_valid),  0);
        chk("rst_w_last",  32'(w_last),   0);
        chk("rst_w_data",  32'(w_data),   0);
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return ((cyc - 1) % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // mode: 0 ready always, 1 pattern 1,0,0, 2 random.
    // spur: issue a second start mid-burst. abort_at: >0 resets after that many words.
    task automatic run_burst(input int base, input int nw, input int mode,
                             input bit spur, input int abort_at);
        int   n;
        int   exp_q[$];
        int   issued = 0;
        int   got = 0;
        int   last_hs = -10;
        bit   seen_valid = 0;
        bit   stall_prev = 0;
        int   prev_data = 0;
        bit   finished = 0;

        n = (nw > 32) ? 32 : nw;
        for (int i = 0; i < n; i++) exp_q.push_back(int'(rom_mem[(base + i) % 32]));

        @(negedge clk);
        start     = 1'b1;
        base_addr = 5'(base);
        num_words = 6'(nw);
        w_ready   = ready_for(mode, 0);

        for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
            @(negedge clk);
            start   = 1'b0;
            w_ready = ready_for(mode, cyc);
            if (spur && cyc == 2) begin
                start     = 1'b1;
                base_addr = 5'($urandom);
                num_words = 6'($urandom_range(0, 32));
            end
            #1;
            if (cyc == 1 && n > 0) chk("first_rom_en", 32'(rom_en), 1);
            if (rom_en) begin
                chk("rom_en_extra", 32'(issued < n), 1);
                chk("rom_addr", 32'(rom_addr), 32'((base + issued) % 32));
                issued++;
            end
            if (stall_prev) begin
                chk("hold_valid", 32'(w_valid), 1);
                chk("hold_data", 32'(w_data), 32'(prev_data));
            end
            if (w_valid && !seen_valid) begin
                chk("first_valid_lat", 32'(cyc), 3);
                seen_valid = 1;
            end
            stall_prev = w_valid && !w_ready;
            prev_data  = int'(w_data);
            if (w_valid && w_ready) begin
                chk("handshake_extra", 32'(got < n), 1);
                if (got < n) begin
                    chk("w_data", 32'(w_data), 32'(exp_q[got]));
                    chk("w_last", 32'(w_last), 32'(got == n - 1));
                end
                if (mode == 0) chk("throughput", 32'(cyc), 32'(3 + got));
                got++;
                if (got == n) last_hs = cyc;
                if (abort_at > 0 && got == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk_reset_outputs();
                    @(negedge clk);
                    chk("abort_no_done", 32'(done), 0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
            end
            if (done) begin
                chk("done_time", 32'(cyc), 32'((n == 0) ? 1 : last_hs + 1));
                chk("busy_in_done", 32'(busy), 1);
                finished = 1;
            end else begin
                chk("busy_during", 32'(busy), 1);
            end
        end
        if (!finished) chk("done_timeout", 0, 1);
        chk("word_count", 32'(got), 32'(n));
        @(negedge clk);
        w_ready = 1'b0;
        #1;
        chk("busy_after", 32'(busy), 0);
        chk("done_after", 32'(done), 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom_mem[i] = 9'(i);
        #2;
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_burst(0, 9, 0, 0, 0);
        run_burst(30, 4, 0, 0, 0);
        run_burst(7, 6, 1, 0, 0);
        run_burst(12, 0, 0, 0, 0);
        run_burst(5, 8, 2, 1, 0);
        run_burst(3, 8, 0, 0, 3);
        run_burst(3, 8, 1, 0, 0);
        run_burst(20, 40, 2, 0, 0);

        for (int i = 0; i < 32; i++) rom_mem[i] = 9'($urandom);
        for (int t = 0; t < 20; t++) begin
            run_burst(int'($urandom_range(0, 31)), int'($urandom_range(0, 34)),
                      int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
